mult_arbiter_bf16: RTL and testbench
====================================

MULT_ARBITER_BF16 -- requirements
Module: mult_arbiter_bf16

Interface
REQ-001 Parameter: N_REQ, default 4, number of requester ports (legal 2..8).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_input_a  input  16*N_REQ  bf16 operand A; slice i = [16*i+15:16*i].
REQ-005 req_input_b  input  16*N_REQ  bf16 operand B, same slicing.
REQ-006 req_input_STB  input  N_REQ  request strobe per requester.
REQ-007 req_BUSY  output  N_REQ  high = request i accepted and in service.
REQ-008 res_output  output  16  shared bf16 product bus.
REQ-009 res_output_STB  output  N_REQ  product valid for requester i.
REQ-010 res_output_BUSY  input  N_REQ  requester i cannot take product.
REQ-011 mult_input_a, mult_input_b  output  16 each  operands to shared multiplier_bf16.
REQ-012 mult_input_STB  output  1  operand strobe to multiplier.
REQ-013 mult_BUSY  input  1  multiplier has accepted operands.
REQ-014 mult_output  input  16  multiplier product.
REQ-015 mult_output_STB  input  1  multiplier product valid.
REQ-016 mult_output_module_BUSY  output  1  arbiter not ready for product.
REQ-017 grant_id  output  3  index of requester in service.
REQ-018 op_count  output  16  completed operations, wraps 0xFFFF->0x0000.

Function
REQ-019 All outputs SHALL be registered; FSM states IDLE, ISSUE, WAIT_RESULT, DELIVER.
REQ-020 IDLE: eligible i = req_input_STB[i]=1 and req_BUSY[i]=0; winner = first eligible scanning from rr_ptr upward, modulo N_REQ.
REQ-021 On the IDLE edge with a winner g: latch a/b slice g into mult_input_a/b, req_BUSY[g]<=1, grant_id<=g, rr_ptr<=(g+1) mod N_REQ, mult_input_STB<=1, go ISSUE.
REQ-022 No eligible requester in IDLE: stay IDLE, rr_ptr unchanged.
REQ-023 Non-winners SHALL see req_BUSY low and keep STB high; requesters drop STB after observing req_BUSY high.
REQ-024 ISSUE: hold mult_input_STB and operands until mult_BUSY=1 sampled; then mult_input_STB<=0, mult_output_module_BUSY<=0, go WAIT_RESULT.
REQ-025 WAIT_RESULT: on edge with mult_output_STB=1 and mult_output_module_BUSY=0: res_output<=mult_output, mult_output_module_BUSY<=1, res_output_STB[grant_id]<=1, go DELIVER.
REQ-026 DELIVER: on edge with res_output_STB[g]=1 and res_output_BUSY[g]=0: res_output_STB[g]<=0, req_BUSY[g]<=0, op_count<=op_count+1, go IDLE.
REQ-027 At most one bit of req_BUSY and of res_output_STB SHALL be high at any time; res_output stable while any res_output_STB high.
REQ-028 Arbiter adds no combinational paths; minimum request-to-result latency = 3 cycles + multiplier latency + 1 delivery cycle.
REQ-029 Requester g re-requesting on the cycle it returns to IDLE is eligible but loses to any other eligible requester after it in round-robin order.
REQ-030 Requests on non-granted ports during ISSUE/WAIT_RESULT/DELIVER SHALL be ignored (not queued) and remain pending.
REQ-031 grant_id holds last winner when IDLE.

Reset
REQ-032 rst high on any edge SHALL force IDLE regardless of state, aborting an in-flight operation with no product delivered.
REQ-033 Reset values: req_BUSY=0, res_output_STB=0, res_output=0, mult_input_STB=0, mult_input_a/b=0, mult_output_module_BUSY=1, grant_id=0, op_count=0, rr_ptr=0.
REQ-034 Multiplier SHALL share rst; a product arriving after reset is never accepted because mult_output_module_BUSY=1.

Verification
REQ-035 Single request: port 0 a=0x4000 (2.0), b=0x3FC0 (1.5) -> res_output=0x4040, res_output_STB=0001, op_count=1.
REQ-036 Simultaneous requests all 4 ports after reset -> service order 0,1,2,3; each res_output_STB one-hot to matching port.
REQ-037 Port 1 holds STB continuously, port 3 requests once -> order 1,3,1 (fairness).
REQ-038 res_output_BUSY[2]=1 for 10 cycles during DELIVER -> res_output_STB[2] and res_output held stable, no new grant, op_count increments once when released.
REQ-039 rst asserted one cycle in WAIT_RESULT -> next cycle all REQ-033 values; following request on port 0 (0x3F80 x 0x40C0) returns 0x40C0.
REQ-040 mult_BUSY delayed 5 cycles in ISSUE -> mult_input_STB and operands held constant throughout, deasserted one cycle after mult_BUSY sampled high.

Source files
------------

// File: rtl/mult_arbiter_bf16.sv
// mult_arbiter_bf16: round-robin arbiter sharing one bf16 multiplier among N_REQ requesters
module mult_arbiter_bf16 #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*N_REQ-1:0]  req_input_a,
  input  logic [16*N_REQ-1:0]  req_input_b,
  input  logic [N_REQ-1:0]     req_input_STB,
  output logic [N_REQ-1:0]     req_BUSY,
  output logic [15:0]          res_output,
  output logic [N_REQ-1:0]     res_output_STB,
  input  logic [N_REQ-1:0]     res_output_BUSY,
  output logic [15:0]          mult_input_a,
  output logic [15:0]          mult_input_b,
  output logic                 mult_input_STB,
  input  logic                 mult_BUSY,
  input  logic [15:0]          mult_output,
  input  logic                 mult_output_STB,
  output logic                 mult_output_module_BUSY,
  output logic [2:0]           grant_id,
  output logic [15:0]          op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, DELIVER} state_t;
  state_t state_q, state_d;
  logic [N_REQ-1:0] req_busy_q, req_busy_d, res_stb_q, res_stb_d, elig, rot;
  logic [15:0] res_q, res_d, a_q, a_d, b_q, b_d, op_q, op_d;
  logic stb_q, stb_d, mod_busy_q, mod_busy_d;
  logic [2:0] grant_q, grant_d, rr_q, rr_d, win;
  logic [3:0] off, sum;
  logic [2*N_REQ-1:0] dbl;
  assign elig = req_input_STB & ~req_busy_q;
  assign dbl = {elig, elig} >> rr_q;
  assign rot = dbl[N_REQ-1:0];
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) off = rot[k] ? 4'(k) : off;
    sum = {1'b0, rr_q} + off;
    win = 3'(sum >= 4'(N_REQ) ? sum - 4'(N_REQ) : sum);
  end
  always_comb begin
    state_d = state_q;
    req_busy_d = req_busy_q;
    res_stb_d = res_stb_q;
    res_d = res_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    stb_d = stb_q;
    mod_busy_d = mod_busy_q;
    grant_d = grant_q;
    rr_d = rr_q;
    case (state_q)
      IDLE: if (|elig) begin
        a_d = req_input_a[16*win +: 16];
        b_d = req_input_b[16*win +: 16];
        req_busy_d = N_REQ'(1) << win;
        grant_d = win;
        rr_d = (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
        stb_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (mult_BUSY) begin
        stb_d = 1'b0;
        mod_busy_d = 1'b0;
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: if (mult_output_STB && !mod_busy_q) begin
        res_d = mult_output;
        mod_busy_d = 1'b1;
        res_stb_d = N_REQ'(1) << grant_q;
        state_d = DELIVER;
      end
      DELIVER: if (|(res_stb_q & ~res_output_BUSY)) begin
        res_stb_d = '0;
        req_busy_d = '0;
        op_d = op_q + 16'd1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_busy_q <= '0;
      res_stb_q <= '0;
      res_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      stb_q <= 1'b0;
      mod_busy_q <= 1'b1;
      grant_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      req_busy_q <= req_busy_d;
      res_stb_q <= res_stb_d;
      res_q <= res_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      stb_q <= stb_d;
      mod_busy_q <= mod_busy_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
    end
  end
  assign req_BUSY = req_busy_q;
  assign res_output = res_q;
  assign res_output_STB = res_stb_q;
  assign mult_input_a = a_q;
  assign mult_input_b = b_q;
  assign mult_input_STB = stb_q;
  assign mult_output_module_BUSY = mod_busy_q;
  assign grant_id = grant_q;
  assign op_count = op_q;
endmodule

// File: tb/tb_mult_arbiter_bf16.sv
// tb_mult_arbiter_bf16: randomized self-checking bench with behavioural multiplier and round-robin model
module tb_mult_arbiter_bf16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [63:0] req_a, req_b;
  logic [3:0] req_stb, req_BUSY, res_output_STB, res_busy;
  logic [15:0] res_output, mult_input_a, mult_input_b, mult_out, op_count;
  logic mult_input_STB, mult_busy, mult_out_stb, mult_output_module_BUSY;
  logic [2:0] grant_id;
  mult_arbiter_bf16 #(.N_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_input_a(req_a), .req_input_b(req_b), .req_input_STB(req_stb),
    .req_BUSY(req_BUSY), .res_output(res_output), .res_output_STB(res_output_STB),
    .res_output_BUSY(res_busy), .mult_input_a(mult_input_a), .mult_input_b(mult_input_b),
    .mult_input_STB(mult_input_STB), .mult_BUSY(mult_busy), .mult_output(mult_out),
    .mult_output_STB(mult_out_stb), .mult_output_module_BUSY(mult_output_module_BUSY),
    .grant_id(grant_id), .op_count(op_count)
  );
  int checks = 0, errors = 0;
  logic [3:0] hold, prev_rstb;
  logic [15:0] prev_res, m_a, m_b, ea, eb;
  int m_state, m_cnt, acc_delay, m_lat, rr_model;
  int got_port[$];
  logic [15:0] got_val[$];
  logic [15:0] op_a[4], op_b[4];
  function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    int e;
    p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) return {a[15] ^ b[15], 8'(e + 1), p[14:8]};
    return {a[15] ^ b[15], 8'(e), p[13:7]};
  endfunction
  function automatic int pick(input logic [3:0] m, input int rr);
    for (int k = 0; k < 4; k++) if (m[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction
  function automatic logic [15:0] rnd_bf();
    return {1'($urandom), 8'($urandom_range(110, 140)), 7'($urandom)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("req_busy_onehot0", 32'($onehot0(req_BUSY)), 1);
    chk("res_stb_onehot0", 32'($onehot0(res_output_STB)), 1);
    if (res_output_STB != 0 && res_output_STB == prev_rstb) chk("res_stable", res_output, prev_res);
    for (int i = 0; i < 4; i++)
      if (res_output_STB[i] && !prev_rstb[i]) begin
        got_port.push_back(i);
        got_val.push_back(res_output);
      end
    prev_rstb = res_output_STB;
    prev_res = res_output;
    for (int i = 0; i < 4; i++) if (req_stb[i] && req_BUSY[i] && !hold[i]) req_stb[i] = 1'b0;
    if (rst) begin
      m_state = 0;
      mult_busy = 1'b0;
      mult_out_stb = 1'b0;
    end else if (m_state == 0) begin
      if (mult_input_STB) begin
        m_cnt = acc_delay;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_cnt == 0) begin
        mult_busy = 1'b1;
        m_a = mult_input_a;
        m_b = mult_input_b;
        m_cnt = m_lat;
        m_state = 2;
      end else m_cnt--;
    end else if (m_state == 2) begin
      mult_busy = 1'b0;
      if (m_cnt == 0) begin
        mult_out = bf_mul(m_a, m_b);
        mult_out_stb = 1'b1;
        m_state = 3;
      end else m_cnt--;
    end else if (mult_output_module_BUSY) begin
      mult_out_stb = 1'b0;
      m_state = 0;
    end
  endtask
  task automatic run_until(input int n, input int budget, input string tag);
    int c = 0;
    while (got_port.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, 32'(got_port.size() >= n), 1);
  endtask
  task automatic do_reset();
    req_stb = '0;
    hold = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_model = 0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_req_busy"}, req_BUSY, 0);
    chk({tag, "_res_stb"}, res_output_STB, 0);
    chk({tag, "_res"}, res_output, 0);
    chk({tag, "_mstb"}, mult_input_STB, 0);
    chk({tag, "_ma"}, mult_input_a, 0);
    chk({tag, "_mb"}, mult_input_b, 0);
    chk({tag, "_mod_busy"}, mult_output_module_BUSY, 1);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask
  task automatic load(input int i);
    req_a[16*i +: 16] = op_a[i];
    req_b[16*i +: 16] = op_b[i];
    req_stb[i] = 1'b1;
  endtask
  task automatic serve(input logic [3:0] mask, input string tag);
    int order[$];
    int rr, p;
    logic [3:0] m;
    logic [15:0] oc0;
    got_port.delete();
    got_val.delete();
    m = mask;
    rr = rr_model;
    while (m != 0) begin
      p = pick(m, rr);
      order.push_back(p);
      m[p] = 1'b0;
      rr = (p + 1) % 4;
    end
    rr_model = rr;
    oc0 = op_count;
    for (int i = 0; i < 4; i++) if (mask[i]) load(i);
    run_until(order.size(), 100 * order.size(), tag);
    for (int k = 0; k < order.size() && k < got_port.size(); k++) begin
      chk({tag, "_port"}, got_port[k], order[k]);
      chk({tag, "_val"}, got_val[k], bf_mul(op_a[order[k]], op_b[order[k]]));
    end
    tick();
    chk({tag, "_op_count"}, op_count, 16'(oc0 + order.size()));
  endtask
  initial begin
    int c, held, p, rr;
    logic [3:0] m;
    int exp_ord[3];
    logic [15:0] oc0;
    rst = 1'b1;
    req_a = '0;
    req_b = '0;
    req_stb = '0;
    hold = '0;
    res_busy = '0;
    mult_busy = 1'b0;
    mult_out_stb = 1'b0;
    mult_out = '0;
    prev_rstb = '0;
    prev_res = '0;
    m_state = 0;
    m_cnt = 0;
    acc_delay = 0;
    m_lat = 2;
    do_reset();
    check_reset("reset");
    op_a[0] = 16'h4000;
    op_b[0] = 16'h3FC0;
    serve(4'b0001, "single");
    if (got_val.size() > 0) chk("single_lit", got_val[0], 16'h4040);
    chk("single_cnt", op_count, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op_a[i] = rnd_bf();
      op_b[i] = rnd_bf();
    end
    serve(4'b1111, "all4");
    got_port.delete();
    got_val.delete();
    op_a[1] = rnd_bf();
    op_b[1] = rnd_bf();
    op_a[3] = rnd_bf();
    op_b[3] = rnd_bf();
    m = 4'b1010;
    rr = rr_model;
    for (int k = 0; k < 3; k++) begin
      p = pick(m, rr);
      exp_ord[k] = p;
      if (p != 1) m[p] = 1'b0;
      rr = (p + 1) % 4;
    end
    rr_model = rr;
    hold[1] = 1'b1;
    load(1);
    load(3);
    run_until(3, 300, "fair");
    hold[1] = 1'b0;
    req_stb[1] = 1'b0;
    for (int k = 0; k < 3 && k < got_port.size(); k++) chk("fair_port", got_port[k], exp_ord[k]);
    repeat (10) tick();
    chk("fair_no_extra", got_port.size(), 3);
    chk("fair_idle_busy", req_BUSY, 0);
    got_port.delete();
    got_val.delete();
    op_a[2] = rnd_bf();
    op_b[2] = rnd_bf();
    op_a[0] = rnd_bf();
    op_b[0] = rnd_bf();
    res_busy[2] = 1'b1;
    load(2);
    run_until(1, 100, "hold");
    load(0);
    oc0 = op_count;
    repeat (10) begin
      tick();
      chk("hold_stb", res_output_STB, 4'b0100);
      chk("hold_val", res_output, bf_mul(op_a[2], op_b[2]));
      chk("hold_cnt", op_count, oc0);
      chk("hold_no_grant", req_BUSY, 4'b0100);
    end
    res_busy[2] = 1'b0;
    tick();
    chk("hold_release_cnt", op_count, 16'(oc0 + 1));
    chk("hold_release_stb", res_output_STB, 0);
    run_until(2, 100, "hold_next");
    if (got_port.size() > 1) begin
      chk("hold_first", got_port[0], 2);
      chk("hold_next_port", got_port[1], 0);
      chk("hold_next_val", got_val[1], bf_mul(op_a[0], op_b[0]));
    end
    tick();
    got_port.delete();
    got_val.delete();
    m_lat = 6;
    op_a[1] = rnd_bf();
    op_b[1] = rnd_bf();
    load(1);
    c = 0;
    while (mult_output_module_BUSY && c < 50) begin
      tick();
      c++;
    end
    chk("rst_reach_wait", mult_output_module_BUSY, 0);
    tick();
    do_reset();
    check_reset("midrst");
    repeat (12) tick();
    chk("midrst_no_result", got_port.size(), 0);
    chk("midrst_mod_busy", mult_output_module_BUSY, 1);
    m_lat = 2;
    op_a[0] = 16'h3F80;
    op_b[0] = 16'h40C0;
    serve(4'b0001, "after_rst");
    if (got_val.size() > 0) chk("after_rst_lit", got_val[0], 16'h40C0);
    got_port.delete();
    got_val.delete();
    acc_delay = 5;
    op_a[3] = rnd_bf();
    op_b[3] = rnd_bf();
    load(3);
    tick();
    chk("issue_busy", req_BUSY, 4'b1000);
    chk("issue_stb", mult_input_STB, 1);
    chk("issue_a", mult_input_a, op_a[3]);
    ea = mult_input_a;
    eb = mult_input_b;
    held = 0;
    c = 0;
    while (!mult_busy && c < 30) begin
      chk("issue_hold_stb", mult_input_STB, 1);
      chk("issue_hold_a", mult_input_a, ea);
      chk("issue_hold_b", mult_input_b, eb);
      held++;
      tick();
      c++;
    end
    chk("issue_stb_at_busy", mult_input_STB, 1);
    tick();
    chk("issue_stb_drop", mult_input_STB, 0);
    chk("issue_held_len", 32'(held >= 5), 1);
    run_until(1, 100, "issue_res");
    if (got_val.size() > 0) chk("issue_val", got_val[0], bf_mul(op_a[3], op_b[3]));
    rr_model = 0;
    tick();
    acc_delay = 0;
    for (int r = 0; r < 8; r++) begin
      m_lat = $urandom_range(0, 4);
      acc_delay = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        op_a[i] = rnd_bf();
        op_b[i] = rnd_bf();
      end
      serve(4'($urandom_range(1, 15)), "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
